// File: rtl/file_proto_pkg.sv
// Shared definitions for the byte-serial file transfer protocol: command
// bytes, responder state encoding and the file-length table used by both
// ends of the link.
package file_proto_pkg;

    // Command bytes ('R' and 'W')
    localparam logic [7:0] CMD_READ  = 8'd82;
    localparam logic [7:0] CMD_WRITE = 8'd87;

    // Responder states
    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_GET_HI     = 4'd1,
        ST_GET_LO     = 4'd2,
        ST_LOOKUP     = 4'd3,
        ST_READ_FETCH = 4'd4,
        ST_READ_LATCH = 4'd5,
        ST_READ_SEND  = 4'd6,
        ST_READ_GUARD = 4'd7,
        ST_READ_WAIT  = 4'd8,
        ST_WRITE_RECV = 4'd9,
        ST_DONE       = 4'd10
    } state_t;

    // Transfer direction latched from the command byte
    typedef enum logic {
        DIR_READ  = 1'b0,
        DIR_WRITE = 1'b1
    } dir_t;

    // File length by index. Indices outside every range have no file and
    // report length 0, which the responder treats as a bad index.
    function automatic logic [31:0] file_len_lookup(input logic [31:0] idx);
        logic [31:0] len;
        len = 32'd0;
        if (idx == 32'd0) begin
            len = 32'd784;
        end else if (idx <= 32'd32) begin
            len = 32'd25;
        end else if (idx <= 32'd96) begin
            len = 32'd784;
        end else if (idx <= 32'd160) begin
            len = 32'd196;
        end else if (idx <= 32'd2208) begin
            len = 32'd25;
        end else if (idx <= 32'd2337) begin
            len = 32'd196;
        end else if (idx <= 32'd2401) begin
            len = 32'd49;
        end else if (idx <= 32'd2445) begin
            len = 32'd784;
        end else if (idx <= 32'd2447) begin
            len = 32'd10;
        end
        return len;
    endfunction

endpackage

// File: rtl/file_len_rom.sv
// Combinational file index -> file length table. The same module is used on
// the initiator side so that both ends agree on every file's length.
module file_len_rom
    import file_proto_pkg::*;
#(
    parameter int IDX_W = 16,
    parameter int LEN_W = 16
) (
    input  logic [IDX_W-1:0] idx,
    output logic [LEN_W-1:0] len
);

    // Table lookup on the zero-extended index
    always_comb begin
        len = LEN_W'(file_len_lookup(32'(idx)));
    end

endmodule

// File: rtl/file_responder.sv
// Far-end responder for the byte-serial file transfer protocol. Decodes a
// 3-byte command ('R'/'W' + 16-bit file index, high byte first), then either
// streams the file out of the byte-wide store through the UART or writes the
// incoming payload bytes into the store.
module file_responder
    import file_proto_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1_000_000,
    parameter int IDX_W          = 16,
    parameter int LEN_W          = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       rx_data,
    input  logic             rx_rdy,
    output logic [7:0]       tx_data,
    output logic             tx_en,
    input  logic             tx_busy,
    output logic [IDX_W-1:0] st_file,
    output logic [LEN_W-1:0] st_offset,
    output logic             st_re,
    input  logic [7:0]       st_rdata,
    output logic             st_we,
    output logic [7:0]       st_wdata,
    output logic             busy,
    output logic             xfer_done,
    output logic             cmd_err
);

    localparam int GAP_W = $clog2(TIMEOUT_CYCLES + 1);

    // Control state
    state_t           state_reg;
    dir_t             dir_reg;
    logic [7:0]       idx_hi_reg;
    logic [IDX_W-1:0] idx_reg;
    logic [LEN_W-1:0] len_reg;
    logic [LEN_W-1:0] cnt_reg;
    logic [GAP_W-1:0] gap_reg;

    // Registered outputs
    logic [7:0]       tx_data_reg;
    logic             tx_en_reg;
    logic [IDX_W-1:0] st_file_reg;
    logic [LEN_W-1:0] st_offset_reg;
    logic             st_re_reg;
    logic             st_we_reg;
    logic [7:0]       st_wdata_reg;
    logic             xfer_done_reg;
    logic             cmd_err_reg;

    // Derived values
    logic [LEN_W-1:0] rom_len;
    logic [LEN_W:0]   cnt_inc;
    logic             last_byte;
    logic             gap_expired;

    file_len_rom #(
        .IDX_W (IDX_W),
        .LEN_W (LEN_W)
    ) u_len_rom (
        .idx (idx_reg),
        .len (rom_len)
    );

    // Offset increment and end-of-file test, one bit wider than the counter
    // so the compare against len can never be fooled by a wrap.
    always_comb begin
        cnt_inc     = {1'b0, cnt_reg} + (LEN_W + 1)'(1);
        last_byte   = (cnt_inc == {1'b0, len_reg});
        gap_expired = (gap_reg == GAP_W'(TIMEOUT_CYCLES - 1));
    end

    // Protocol FSM: every output is a register updated on the state transition
    // so strobes are high during the state they belong to.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            dir_reg       <= DIR_READ;
            idx_hi_reg    <= 8'd0;
            idx_reg       <= '0;
            len_reg       <= '0;
            cnt_reg       <= '0;
            gap_reg       <= '0;
            tx_data_reg   <= 8'd0;
            tx_en_reg     <= 1'b0;
            st_file_reg   <= '0;
            st_offset_reg <= '0;
            st_re_reg     <= 1'b0;
            st_we_reg     <= 1'b0;
            st_wdata_reg  <= 8'd0;
            xfer_done_reg <= 1'b0;
            cmd_err_reg   <= 1'b0;
        end else begin
            // Strobes default low; each is a single-cycle pulse
            tx_en_reg     <= 1'b0;
            st_re_reg     <= 1'b0;
            st_we_reg     <= 1'b0;
            xfer_done_reg <= 1'b0;
            cmd_err_reg   <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    // Anything but a command byte is dropped silently
                    if (rx_rdy) begin
                        if (rx_data == CMD_READ) begin
                            dir_reg   <= DIR_READ;
                            gap_reg   <= '0;
                            state_reg <= ST_GET_HI;
                        end else if (rx_data == CMD_WRITE) begin
                            dir_reg   <= DIR_WRITE;
                            gap_reg   <= '0;
                            state_reg <= ST_GET_HI;
                        end
                    end
                end

                ST_GET_HI: begin
                    if (rx_rdy) begin
                        idx_hi_reg <= rx_data;
                        gap_reg    <= '0;
                        state_reg  <= ST_GET_LO;
                    end else if (gap_expired) begin
                        cmd_err_reg <= 1'b1;
                        state_reg   <= ST_IDLE;
                    end else begin
                        gap_reg <= gap_reg + GAP_W'(1);
                    end
                end

                ST_GET_LO: begin
                    if (rx_rdy) begin
                        idx_reg   <= IDX_W'({idx_hi_reg, rx_data});
                        gap_reg   <= '0;
                        state_reg <= ST_LOOKUP;
                    end else if (gap_expired) begin
                        cmd_err_reg <= 1'b1;
                        state_reg   <= ST_IDLE;
                    end else begin
                        gap_reg <= gap_reg + GAP_W'(1);
                    end
                end

                ST_LOOKUP: begin
                    // st_file follows the index even when it turns out empty
                    st_file_reg <= idx_reg;
                    len_reg     <= rom_len;
                    cnt_reg     <= '0;
                    if (rom_len == '0) begin
                        cmd_err_reg <= 1'b1;
                        state_reg   <= ST_IDLE;
                    end else if (dir_reg == DIR_READ) begin
                        st_re_reg     <= 1'b1;
                        st_offset_reg <= '0;
                        state_reg     <= ST_READ_FETCH;
                    end else begin
                        gap_reg   <= '0;
                        state_reg <= ST_WRITE_RECV;
                    end
                end

                ST_READ_FETCH: begin
                    // st_re is high this cycle; data arrives next cycle
                    state_reg <= ST_READ_LATCH;
                end

                ST_READ_LATCH: begin
                    tx_data_reg <= st_rdata;
                    state_reg   <= ST_READ_SEND;
                end

                ST_READ_SEND: begin
                    if (!tx_busy) begin
                        tx_en_reg <= 1'b1;
                        state_reg <= ST_READ_GUARD;
                    end
                end

                ST_READ_GUARD: begin
                    // tx_en is high here; tx_busy has not risen yet, so skip it
                    state_reg <= ST_READ_WAIT;
                end

                ST_READ_WAIT: begin
                    if (!tx_busy) begin
                        cnt_reg <= cnt_inc[LEN_W-1:0];
                        if (last_byte) begin
                            state_reg <= ST_DONE;
                        end else begin
                            st_re_reg     <= 1'b1;
                            st_offset_reg <= cnt_inc[LEN_W-1:0];
                            state_reg     <= ST_READ_FETCH;
                        end
                    end
                end

                ST_WRITE_RECV: begin
                    if (rx_rdy) begin
                        st_we_reg     <= 1'b1;
                        st_wdata_reg  <= rx_data;
                        st_offset_reg <= cnt_reg;
                        cnt_reg       <= cnt_inc[LEN_W-1:0];
                        gap_reg       <= '0;
                        if (last_byte) begin
                            state_reg <= ST_DONE;
                        end
                    end else if (gap_expired) begin
                        cmd_err_reg <= 1'b1;
                        state_reg   <= ST_IDLE;
                    end else begin
                        gap_reg <= gap_reg + GAP_W'(1);
                    end
                end

                ST_DONE: begin
                    xfer_done_reg <= 1'b1;
                    state_reg     <= ST_IDLE;
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // Output wiring
    assign tx_data   = tx_data_reg;
    assign tx_en     = tx_en_reg;
    assign st_file   = st_file_reg;
    assign st_offset = st_offset_reg;
    assign st_re     = st_re_reg;
    assign st_we     = st_we_reg;
    assign st_wdata  = st_wdata_reg;
    assign xfer_done = xfer_done_reg;
    assign cmd_err   = cmd_err_reg;
    assign busy      = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_file_responder.sv
// Self-checking bench for file_responder: a table of whole-command vectors
// plus hand-written sequences for the zero-length lookup, timeout and reset.
module tb_file_responder;

    localparam int TO = 300;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_rdy = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_en;
    logic        tx_busy;
    logic [15:0] st_file;
    logic [15:0] st_offset;
    logic        st_re;
    logic [7:0]  st_rdata = 8'd0;
    logic        st_we;
    logic [7:0]  st_wdata;
    logic        busy;
    logic        xfer_done;
    logic        cmd_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    file_responder #(
        .TIMEOUT_CYCLES (TO),
        .IDX_W          (16),
        .LEN_W          (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_data   (rx_data),
        .rx_rdy    (rx_rdy),
        .tx_data   (tx_data),
        .tx_en     (tx_en),
        .tx_busy   (tx_busy),
        .st_file   (st_file),
        .st_offset (st_offset),
        .st_re     (st_re),
        .st_rdata  (st_rdata),
        .st_we     (st_we),
        .st_wdata  (st_wdata),
        .busy      (busy),
        .xfer_done (xfer_done),
        .cmd_err   (cmd_err)
    );

    // UART transmitter: busy for 10 cycles, rising the cycle after tx_en
    int busy_cnt = 0;
    always @(posedge clk) begin
        if (reset) busy_cnt <= 0;
        else if (tx_en) busy_cnt <= 10;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy = (busy_cnt != 0);

    // File store: byte k of any file reads as k[7:0], one cycle after st_re
    always @(posedge clk) begin
        st_rdata <= st_re ? st_offset[7:0] : 8'h5A;
    end

    // Event logs (cumulative, written only here)
    int          tx_total = 0, we_total = 0, done_total = 0, err_total = 0;
    logic [7:0]  tx_log [8192];
    logic [15:0] we_file_log [8192];
    logic [15:0] we_off_log [8192];
    logic [7:0]  we_data_log [8192];

    always @(negedge clk) begin
        if (tx_en && tx_total < 8192) begin
            tx_log[tx_total] = tx_data;
            tx_total++;
        end
        if (st_we && we_total < 8192) begin
            we_file_log[we_total] = st_file;
            we_off_log[we_total]  = st_offset;
            we_data_log[we_total] = st_wdata;
            we_total++;
        end
        if (xfer_done) done_total++;
        if (cmd_err) err_total++;
    end

    typedef struct {
        bit          is_wr;
        bit          has_pre;
        logic [15:0] idx;
        int          n_wr;
        logic [7:0]  wr_base;
        int          exp_tx;
        int          exp_we;
        int          exp_done;
        int          exp_err;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs [NV];

    function automatic vec_t mk(input bit is_wr, input bit has_pre, input logic [15:0] idx,
                                input int n_wr, input logic [7:0] wr_base, input int exp_tx,
                                input int exp_we, input int exp_done, input int exp_err);
        vec_t r;
        r.is_wr = is_wr; r.has_pre = has_pre; r.idx = idx; r.n_wr = n_wr; r.wr_base = wr_base;
        r.exp_tx = exp_tx; r.exp_we = exp_we; r.exp_done = exp_done; r.exp_err = exp_err;
        return r;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_rdy  = 1'b1;
        @(negedge clk);
        rx_rdy  = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int c;
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (busy && c < budget);
        check("wait_idle", int'(busy), 0);
        repeat (3) @(negedge clk);
    endtask

    int b_tx, b_we, b_done, b_err;

    task automatic snap();
        b_tx = tx_total; b_we = we_total; b_done = done_total; b_err = err_total;
    endtask

    task automatic check_reads(input string name, input int n);
        for (int i = 0; i < n && i < tx_total - b_tx; i++)
            check(name, int'(tx_log[b_tx + i]), i % 256);
    endtask

    task automatic check_writes(input logic [15:0] idx, input logic [7:0] base, input int n);
        for (int i = 0; i < n && i < we_total - b_we; i++) begin
            check("we_file", int'(we_file_log[b_we + i]), int'(idx));
            check("we_offset", int'(we_off_log[b_we + i]), i);
            check("we_data", int'(we_data_log[b_we + i]), (int'(base) + i) % 256);
        end
    endtask

    // Watchdog
    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int seen;
        logic [7:0] cmd;

        vecs[0]  = mk(0, 0, 16'd0,    0,  8'h00, 784, 0,  1, 0);
        vecs[1]  = mk(1, 0, 16'd1,    25, 8'hA0, 0,   25, 1, 0);
        vecs[2]  = mk(0, 0, 16'd4095, 0,  8'h00, 0,   0,  0, 1);
        vecs[3]  = mk(0, 1, 16'd2446, 0,  8'h00, 10,  0,  1, 0);
        vecs[4]  = mk(1, 0, 16'd2447, 10, 8'h30, 0,   10, 1, 0);
        vecs[5]  = mk(0, 0, 16'd200,  0,  8'h00, 25,  0,  1, 0);
        vecs[6]  = mk(0, 0, 16'd2338, 0,  8'h00, 49,  0,  1, 0);
        vecs[7]  = mk(0, 0, 16'd2209, 0,  8'h00, 196, 0,  1, 0);
        vecs[8]  = mk(1, 0, 16'd2448, 0,  8'h00, 0,   0,  0, 1);
        vecs[9]  = mk(0, 0, 16'd32,   0,  8'h00, 25,  0,  1, 0);
        vecs[10] = mk(1, 0, 16'd161,  25, 8'hF0, 0,   25, 1, 0);

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_tx_en", int'(tx_en), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_st_we", int'(st_we), 0);
        check("rst_st_re", int'(st_re), 0);
        check("rst_xfer_done", int'(xfer_done), 0);
        check("rst_cmd_err", int'(cmd_err), 0);
        check("rst_st_file", int'(st_file), 0);
        check("rst_st_offset", int'(st_offset), 0);
        check("rst_tx_data", int'(tx_data), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Table-driven whole-command vectors
        for (int v = 0; v < NV; v++) begin
            snap();
            cmd = vecs[v].is_wr ? 8'd87 : 8'd82;
            if (vecs[v].has_pre) begin
                send_byte(8'h41);
                repeat (2) @(negedge clk);
                send_byte(8'h00);
                repeat (2) @(negedge clk);
                check("pre_ignored_busy", int'(busy), 0);
            end
            send_byte(cmd);
            send_byte(vecs[v].idx[15:8]);
            send_byte(vecs[v].idx[7:0]);
            for (int i = 0; i < vecs[v].n_wr; i++) begin
                repeat (2) @(negedge clk);
                send_byte(8'((int'(vecs[v].wr_base) + i) % 256));
            end
            wait_idle(20000);
            check("tx_count", tx_total - b_tx, vecs[v].exp_tx);
            check("we_count", we_total - b_we, vecs[v].exp_we);
            check("done_count", done_total - b_done, vecs[v].exp_done);
            check("err_count", err_total - b_err, vecs[v].exp_err);
            check_reads("tx_data", vecs[v].exp_tx);
            check_writes(vecs[v].idx, vecs[v].wr_base, vecs[v].exp_we);
            $display("vec %0d cmd=%0d idx=%0d tx=%0d we=%0d done=%0d err=%0d",
                     v, cmd, vecs[v].idx, tx_total - b_tx, we_total - b_we,
                     done_total - b_done, err_total - b_err);
        end

        // Zero-length lookup: busy in LOOKUP, then IDLE with a single cmd_err pulse
        snap();
        send_byte(8'd87);
        send_byte(8'h10);
        send_byte(8'h00);
        check("lookup_busy", int'(busy), 1);
        @(negedge clk);
        check("lookup_err_busy", int'(busy), 0);
        check("lookup_err_pulse", int'(cmd_err), 1);
        @(negedge clk);
        check("lookup_err_one_cycle", int'(cmd_err), 0);
        $display("seq zero_len idx=4096 err=%0d", err_total - b_err);

        // Write timeout after 20 of 49 bytes
        snap();
        send_byte(8'd87);
        send_byte(8'h09);
        send_byte(8'h61);
        for (int i = 0; i < 20; i++) begin
            repeat (2) @(negedge clk);
            send_byte(8'((8'h10 + i) % 256));
        end
        n = 0;
        while (!cmd_err && n < TO + 50) begin
            @(negedge clk);
            n++;
        end
        check("timeout_fired", int'(cmd_err), 1);
        check("timeout_not_early", int'(n >= TO), 1);
        check("timeout_not_late", int'(n <= TO + 1), 1);
        check("timeout_busy", int'(busy), 0);
        repeat (3) @(negedge clk);
        check("timeout_we_count", we_total - b_we, 20);
        check("timeout_done", done_total - b_done, 0);
        check("timeout_err", err_total - b_err, 1);
        check_writes(16'd2401, 8'h10, 20);
        $display("seq timeout idx=2401 we=%0d err=%0d gap=%0d", we_total - b_we, err_total - b_err, n);

        // Reset after the 5th byte of a read, then a fresh read completes
        snap();
        send_byte(8'd82);
        send_byte(8'h00);
        send_byte(8'h00);
        seen = 0;
        n = 0;
        while (seen < 5 && n < 2000) begin
            @(negedge clk);
            n++;
            if (tx_en) seen++;
        end
        check("rst_mid_seen", seen, 5);
        check("rst_mid_busy_before", int'(busy), 1);
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_tx_en", int'(tx_en), 0);
        check("rst_mid_st_re", int'(st_re), 0);
        check("rst_mid_st_we", int'(st_we), 0);
        check("rst_mid_busy", int'(busy), 0);
        reset = 1'b0;
        @(negedge clk);
        check("rst_after_tx_en", int'(tx_en), 0);
        check("rst_after_busy", int'(busy), 0);
        repeat (20) @(negedge clk);
        check("rst_abort_tx_count", tx_total - b_tx, 5);
        $display("seq reset_mid_read tx_before_reset=%0d", tx_total - b_tx);

        snap();
        send_byte(8'd82);
        send_byte(8'h00);
        send_byte(8'h01);
        wait_idle(5000);
        check("post_rst_tx_count", tx_total - b_tx, 25);
        check("post_rst_done", done_total - b_done, 1);
        check("post_rst_file", int'(st_file), 1);
        check_reads("post_rst_tx_data", 25);
        $display("seq post_reset_read idx=1 tx=%0d done=%0d", tx_total - b_tx, done_total - b_done);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
